nfree_addr_ram: RTL
===================

// Module: nfree_addr_ram
// PURPOSE
//   Responder end of the N_FREE_ADDRESS___LT local-memory interface driven by nmalloc.
//   Dual-port, word-addressed RAM that holds the free-address table and answers nmalloc's port A/B requests.
//   After reset it seeds every entry with a free heap address, then serves reads/writes with fixed pipelined latency.
//   Stalled by memory_controller_waitrequest exactly like the HLS datapath it serves.
// PARAMETERS
//   DATA_WIDTH    32      word width of in_*/out_*
//   ADDR_WIDTH    4       address width; DEPTH = 2**ADDR_WIDTH entries
//   BE_WIDTH      1       byte-enable lanes; lane k covers bits [k*DATA_WIDTH/BE_WIDTH +: DATA_WIDTH/BE_WIDTH]
//   READ_LATENCY  1       enable_x to out_x valid, in cycles; legal values 1 or 2
//   INIT_BASE     32'h0   value seeded into entry 0
//   INIT_STRIDE   32'h40  increment per entry: entry i = INIT_BASE + i*INIT_STRIDE (mod 2**DATA_WIDTH)
// PORTS
//   clk                                 in   1           system clock; all logic on posedge
//   reset                               in   1           synchronous, active-high
//   memory_controller_waitrequest       in   1           1 = freeze all state (clock-enable low)
//   init_done                           out  1           1 = seeding finished, ports live
//   N_FREE_ADDRESS___LT_enable_a        in   1           port A access request
//   N_FREE_ADDRESS___LT_write_enable_a  in   1           port A write (qualified by enable_a)
//   N_FREE_ADDRESS___LT_address_a       in   ADDR_WIDTH  port A word address
//   N_FREE_ADDRESS___LT_in_a            in   DATA_WIDTH  port A write data
//   N_FREE_ADDRESS___LT_byteena_a       in   BE_WIDTH    port A write lane mask
//   N_FREE_ADDRESS___LT_out_a           out  DATA_WIDTH  port A read data
//   (port B: identical set with suffix _b)
// BEHAVIOUR
//   Reset: init_done=0, out_a=out_b=0, read pipelines cleared, FSM -> INIT, init counter=0.
//   Reset takes priority over waitrequest; reset mid-INIT or mid-READY restarts the seeding sweep from entry 0.
//   FSM:
//     INIT:  one entry per non-stalled cycle; mem[cnt] <= INIT_BASE + cnt*INIT_STRIDE, cnt++.
//            After writing entry DEPTH-1 -> READY.
//            Requests are ignored: no write, out_* held 0.
//     READY: init_done=1 from the first READY cycle; serves ports; no exit except reset.
//   Seeding takes exactly DEPTH non-stalled cycles; init_done rises on the following edge.
//   Write: enable_x & write_enable_x at edge -> each lane k with byteena_x[k]=1 updated; other lanes keep old value.
//   Read: enable_x & !write_enable_x -> out_x = mem[address_x] sampled at that edge, visible READ_LATENCY edges later.
//   out_x holds its last value until the next read result on that port.
//   A write request updates the RAM but never changes out_x.
//   Read-during-write, same address (same port or cross port): reader gets OLD data (read-first).
//   Both ports write the same address in one cycle:
//     lanes enabled on both ports take port A data;
//     lanes enabled on one port only take that port's data.
//   enable_x=0: port x idle; write_enable/byteena/in/address are don't-care.
//   Waitrequest=1: RAM, FSM, init counter, read pipeline and out_* all frozen; requests that cycle are dropped.
//   Latency is therefore READ_LATENCY non-stalled cycles.
//   Addresses are always in range (DEPTH = 2**ADDR_WIDTH); no wrap logic beyond natural truncation.
//   Seed arithmetic is truncated to DATA_WIDTH bits.
// TESTING
//   1. Reset 1 cycle, defaults: init_done rises exactly 16 cycles after reset falls.
//      Then reads of A:0, B:15 -> out_a=32'h0 and out_b=32'h3C0 one cycle later.
//   2. Port A writes 32'hDEAD_BEEF @5, byteena=1; next cycle port B reads @5 -> out_b=32'hDEADBEEF.
//      With byteena=0 the same sequence -> out_b=32'h140.
//   3. Same cycle: A writes 32'h1111 @3, B reads @3 -> out_b=32'hC0 (old data).
//      Following cycle B reads @3 -> out_b=32'h1111.
//   4. A and B both write @7 (A=32'hAAAA, B=32'hBBBB), both byteena=1; read @7 -> 32'hAAAA.
//   5. READ_LATENCY=2 with waitrequest=1 for 3 cycles between request and result:
//      out_a changes exactly 2 non-stalled edges after the request.
//      Requests issued during the stall cause no RAM change.
//   6. Reset asserted at seed count 8, then released:
//      init_done stays 0 for 16 more cycles; all 16 entries read back as their seed values.

Source files
------------

// File: rtl/nfree_addr_ram.sv
// Dual-port free-address table for nmalloc: seeds every entry with a heap address after reset,
// then serves port A/B reads (read-first, fixed latency) and byte-lane writes, frozen by waitrequest.
module nfree_addr_ram #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    BE_WIDTH     = 1,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE    = '0,
    parameter logic [DATA_WIDTH-1:0] INIT_STRIDE  = 'h40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_controller_waitrequest,
    output logic                  init_done,
    input  logic                  N_FREE_ADDRESS___LT_enable_a,
    input  logic                  N_FREE_ADDRESS___LT_write_enable_a,
    input  logic [ADDR_WIDTH-1:0] N_FREE_ADDRESS___LT_address_a,
    input  logic [DATA_WIDTH-1:0] N_FREE_ADDRESS___LT_in_a,
    input  logic [BE_WIDTH-1:0]   N_FREE_ADDRESS___LT_byteena_a,
    output logic [DATA_WIDTH-1:0] N_FREE_ADDRESS___LT_out_a,
    input  logic                  N_FREE_ADDRESS___LT_enable_b,
    input  logic                  N_FREE_ADDRESS___LT_write_enable_b,
    input  logic [ADDR_WIDTH-1:0] N_FREE_ADDRESS___LT_address_b,
    input  logic [DATA_WIDTH-1:0] N_FREE_ADDRESS___LT_in_b,
    input  logic [BE_WIDTH-1:0]   N_FREE_ADDRESS___LT_byteena_b,
    output logic [DATA_WIDTH-1:0] N_FREE_ADDRESS___LT_out_b
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / BE_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   seed;
    logic                    run;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                             en, we, rd;
    logic [1:0][ADDR_WIDTH-1:0]             addr;
    logic [1:0][DATA_WIDTH-1:0]             wdata, dout, hold;
    logic [1:0][BE_WIDTH-1:0]               be;
    logic [1:0][READ_LATENCY-1:0]           pv;
    logic [1:0][READ_LATENCY-1:0][DATA_WIDTH-1:0] pd;

    assign en    = {N_FREE_ADDRESS___LT_enable_b,       N_FREE_ADDRESS___LT_enable_a};
    assign we    = {N_FREE_ADDRESS___LT_write_enable_b, N_FREE_ADDRESS___LT_write_enable_a};
    assign addr  = {N_FREE_ADDRESS___LT_address_b,      N_FREE_ADDRESS___LT_address_a};
    assign wdata = {N_FREE_ADDRESS___LT_in_b,           N_FREE_ADDRESS___LT_in_a};
    assign be    = {N_FREE_ADDRESS___LT_byteena_b,      N_FREE_ADDRESS___LT_byteena_a};

    assign run       = !memory_controller_waitrequest;
    assign init_done = (state_q == ST_READY);
    assign seed      = INIT_BASE + DATA_WIDTH'(cnt_q) * INIT_STRIDE;
    assign rd        = init_done ? (en & ~we) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else if (run) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1))
                state_d = ST_READY;
        end
    end

    // Port B is applied first so port A wins on lanes both ports enable.
    always_ff @(posedge clk) begin
        if (!reset && run) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= seed;
            end else begin
                for (int p = 1; p >= 0; p--)
                    if (en[p] && we[p])
                        for (int k = 0; k < BE_WIDTH; k++)
                            if (be[p][k])
                                mem[addr[p]][k*LANE_W +: LANE_W] <= wdata[p][k*LANE_W +: LANE_W];
            end
        end
    end

    // mem is sampled before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv   <= '0;
            hold <= '0;
        end else if (run) begin
            for (int p = 0; p < 2; p++) begin
                pv[p][0] <= rd[p];
                pd[p][0] <= mem[addr[p]];
                for (int i = 1; i < READ_LATENCY; i++) begin
                    pv[p][i] <= pv[p][i-1];
                    pd[p][i] <= pd[p][i-1];
                end
                hold[p] <= dout[p];
            end
        end
    end

    always_comb begin
        dout = hold;
        for (int p = 0; p < 2; p++)
            if (pv[p][READ_LATENCY-1])
                dout[p] = pd[p][READ_LATENCY-1];
    end

    assign N_FREE_ADDRESS___LT_out_a = dout[0];
    assign N_FREE_ADDRESS___LT_out_b = dout[1];
endmodule
